// File: rtl/imem_pkg.sv
// Shared types and constants for the programmable instruction memory.
package imem_pkg;
  typedef enum logic {IMEM_IDLE, IMEM_CLEAR} imem_state_e;

  localparam logic [7:0] IMEM_NOP = 8'b11000001;

  // One extra bit so a pointer can represent DEPTH itself.
  function automatic int imem_ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/imem_ram.sv
// Single write port, single registered read port array with write-first bypass.
module imem_ram #(
  parameter int IDX_W  = 5,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [IDX_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_d, rdata_q;

  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = (we && (waddr == raddr)) ? wdata : mem[raddr];
  end

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) rdata_q <= '0;
    else          rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;
endmodule

// File: rtl/imem_prog.sv
// Run-time programmable instruction memory: clear sweep FSM, fetch and program ports.
// Optional sticky program lock enabled with `define IMEM_LOCK_EN.
module imem_prog
  import imem_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 32,
  parameter logic [DATA_W-1:0] INIT_WORD = DATA_W'(IMEM_NOP)
) (
  input  logic              clk,
  input  logic              reset_n,
`ifdef IMEM_LOCK_EN
  input  logic              lock,
`endif
  input  logic              clear,
  output logic              busy,
  input  logic              fetch_req,
  output logic              fetch_ready,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_valid,
  output logic [DATA_W-1:0] fetch_instr,
  output logic              fetch_oob,
  input  logic              prog_valid,
  output logic              prog_ready,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  output logic              prog_err
);
  localparam int PTR_W = imem_ptr_w(DEPTH);
  localparam int IDX_W = PTR_W - 1;
  localparam logic [ADDR_W:0]  DEPTH_A  = (ADDR_W+1)'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  imem_state_e       state_q, state_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic              vld_q, vld_d;
  logic              oob_q, oob_d;
  logic              err_q, err_d;
  logic              fetch_acc, prog_acc, fetch_in, prog_in, clear_en;
  logic              ram_we;
  logic [IDX_W-1:0]  ram_waddr;
  logic [DATA_W-1:0] ram_wdata, ram_rdata;

  assign busy        = (state_q == IMEM_CLEAR);
  assign fetch_ready = !busy;
  assign fetch_acc   = fetch_req && fetch_ready;
  assign prog_acc    = prog_valid && prog_ready;
  assign fetch_in    = {1'b0, fetch_addr} < DEPTH_A;
  assign prog_in     = {1'b0, prog_addr} < DEPTH_A;

`ifdef IMEM_LOCK_EN
  logic locked_q, locked_d;
  assign locked_d   = locked_q || lock;
  assign prog_ready = !busy && !locked_q;
  assign clear_en   = clear && !locked_q;
  always_ff @(posedge clk) begin
    if (!reset_n) locked_q <= 1'b0;
    else          locked_q <= locked_d;
  end
`else
  assign prog_ready = !busy;
  assign clear_en   = clear;
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      IMEM_IDLE: begin
        if (clear_en) begin
          state_d = IMEM_CLEAR;
          ptr_d   = '0;
        end
      end
      IMEM_CLEAR: begin
        if (clear_en) begin
          ptr_d = '0;
        end else if (ptr_q == LAST_PTR) begin
          state_d = IMEM_IDLE;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + PTR_W'(1);
        end
      end
      default: state_d = IMEM_IDLE;
    endcase
  end

  // The sweep owns the write port; programming only happens while idle.
  always_comb begin
    ram_we    = prog_acc && prog_in;
    ram_waddr = prog_addr[IDX_W-1:0];
    ram_wdata = prog_data;
    if (busy) begin
      ram_we    = 1'b1;
      ram_waddr = ptr_q[IDX_W-1:0];
      ram_wdata = INIT_WORD;
    end
  end

  // oob_q persists between fetches so fetch_instr holds its last value.
  always_comb begin
    vld_d = fetch_acc;
    oob_d = fetch_acc ? !fetch_in : oob_q;
    err_d = prog_acc && !prog_in;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IMEM_CLEAR;
      ptr_q   <= '0;
      vld_q   <= 1'b0;
      oob_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      vld_q   <= vld_d;
      oob_q   <= oob_d;
      err_q   <= err_d;
    end
  end

  imem_ram #(.IDX_W(IDX_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) u_ram (
    .clk     (clk),
    .reset_n (reset_n),
    .we      (ram_we),
    .waddr   (ram_waddr),
    .wdata   (ram_wdata),
    .re      (fetch_acc),
    .raddr   (fetch_addr[IDX_W-1:0]),
    .rdata   (ram_rdata)
  );

  assign fetch_valid = vld_q;
  assign fetch_oob   = vld_q && oob_q;
  assign fetch_instr = oob_q ? INIT_WORD : ram_rdata;
  assign prog_err    = err_q;
endmodule
